// File: rtl/cia_bus_sched.sv
// Shares one mos6526 register port between the 6510 (strict priority) and a host/debug port.
// Bus cycles align to the phi2_p/phi2_n strobes; host reads with side effects can be refused.
module cia_bus_sched #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       phi2_p,
    input  logic       phi2_n,
    input  logic       cpu_cs_n,
    input  logic       cpu_rw,
    input  logic [3:0] cpu_rs,
    input  logic [7:0] cpu_db,
    input  logic       host_req,
    input  logic       host_rw,
    input  logic [3:0] host_rs,
    input  logic [7:0] host_wdata,
    input  logic       host_safe,
    output logic       host_ack,
    output logic       host_err,
    output logic [7:0] host_rdata,
    output logic       host_busy,
    output logic       cia_cs_n,
    output logic       cia_rw,
    output logic [3:0] cia_rs,
    output logic [7:0] cia_db_in,
    input  logic [7:0] cia_db_out,
    output logic       owner
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_DRIVE_H, S_DRIVE_C, S_CAPT, S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

    state_t           state;
    logic             h_rw;
    logic [3:0]       h_rs;
    logic [7:0]       h_wdata;
    logic             h_safe;
    logic [CNT_W-1:0] wait_cnt;

    // TOD unlatch, TOD latch and ICR clear are the reads that change CIA state
    function automatic logic side_effect(input logic rw, input logic safe, input logic [3:0] rs);
        return rw && safe && (rs == 4'h8 || rs == 4'hB || rs == 4'hD);
    endfunction

    logic p_edge, cpu_win, accept, pending, pend_refused, to_hit;

    // a coincident phi2_n wins; phi2_p is dropped in that case
    assign p_edge       = phi2_p & ~phi2_n;
    assign cpu_win      = p_edge & ~cpu_cs_n;
    assign accept       = host_req & ~host_busy & ~host_ack & (state == S_IDLE || state == S_DRIVE_C);
    assign pending      = host_busy | accept;
    assign pend_refused = accept ? side_effect(host_rw, host_safe, host_rs)
                                 : side_effect(h_rw, h_safe, h_rs);
    assign to_hit       = ~accept & (wait_cnt >= TO_VAL);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= S_IDLE;
            h_rw       <= 1'b1;
            h_rs       <= '0;
            h_wdata    <= '0;
            h_safe     <= 1'b0;
            wait_cnt   <= '0;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            host_rdata <= '0;
            host_busy  <= 1'b0;
            cia_cs_n   <= 1'b1;
            cia_rw     <= 1'b1;
            cia_rs     <= '0;
            cia_db_in  <= '0;
            owner      <= 1'b0;
        end else begin
            host_ack <= 1'b0;
            host_err <= 1'b0;
            if (accept) begin
                h_rw      <= host_rw;
                h_rs      <= host_rs;
                h_wdata   <= host_wdata;
                h_safe    <= host_safe;
                host_busy <= 1'b1;
                wait_cnt  <= '0;
            end
            case (state)
                S_IDLE, S_WAIT, S_ERR: begin
                    if (state == S_ERR) begin
                        host_ack  <= 1'b1;
                        host_err  <= 1'b1;
                        host_busy <= 1'b0;
                        wait_cnt  <= '0;
                    end
                    if (cpu_win) begin
                        cia_cs_n  <= 1'b0;
                        cia_rw    <= cpu_rw;
                        cia_rs    <= cpu_rs;
                        cia_db_in <= cpu_db;
                        owner     <= 1'b0;
                        state     <= S_DRIVE_C;
                        if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
                    end else if (state == S_ERR) begin
                        state <= S_IDLE;
                    end else if (state == S_IDLE) begin
                        if (accept)
                            state <= side_effect(host_rw, host_safe, host_rs) ? S_ERR : S_WAIT;
                    end else if (wait_cnt >= TO_VAL) begin
                        state    <= S_ERR;
                        wait_cnt <= '0;
                    end else if (p_edge) begin
                        cia_cs_n  <= 1'b0;
                        cia_rw    <= h_rw;
                        cia_rs    <= h_rs;
                        cia_db_in <= h_wdata;
                        owner     <= 1'b1;
                        state     <= S_DRIVE_H;
                    end
                end
                S_DRIVE_C: begin
                    if (phi2_n) begin
                        cia_cs_n <= 1'b1;
                        cia_rw   <= 1'b1;
                        if (!pending) begin
                            state <= S_IDLE;
                        end else if (pend_refused || to_hit) begin
                            state    <= S_ERR;
                            wait_cnt <= '0;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else begin
                        // late CPU write data is picked up right up to phi2_n
                        cia_cs_n  <= 1'b0;
                        cia_rw    <= cpu_rw;
                        cia_rs    <= cpu_rs;
                        cia_db_in <= cpu_db;
                    end
                end
                S_DRIVE_H: begin
                    if (phi2_n) begin
                        cia_cs_n <= 1'b1;
                        cia_rw   <= 1'b1;
                        state    <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    if (h_rw) host_rdata <= cia_db_out;
                    host_ack  <= 1'b1;
                    host_err  <= 1'b0;
                    host_busy <= 1'b0;
                    owner     <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cia_bus_sched.sv
// Bench for cia_bus_sched: a phi2 strobe generator, a CPU driver, a register-file CIA stand-in
// and a transaction-level memory model that predicts every host completion.
`timescale 1ns/1ps
module tb_cia_bus_sched;
    localparam int TO    = 3;
    localparam int CLK_P = 10;

    logic       clk = 1'b0, res_n = 1'b0;
    logic       phi2_p = 1'b0, phi2_n = 1'b0;
    logic       cpu_cs_n = 1'b1, cpu_rw = 1'b1;
    logic [3:0] cpu_rs = '0;
    logic [7:0] cpu_db = '0;
    logic       host_req = 1'b0, host_rw = 1'b1, host_safe = 1'b0;
    logic [3:0] host_rs = '0;
    logic [7:0] host_wdata = '0;
    logic       host_ack, host_err, host_busy, cia_cs_n, cia_rw, owner;
    logic [7:0] host_rdata, cia_db_in;
    logic [3:0] cia_rs;
    logic [7:0] cia_db_out = '0;

    cia_bus_sched #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk(clk), .res_n(res_n), .phi2_p(phi2_p), .phi2_n(phi2_n),
        .cpu_cs_n(cpu_cs_n), .cpu_rw(cpu_rw), .cpu_rs(cpu_rs), .cpu_db(cpu_db),
        .host_req(host_req), .host_rw(host_rw), .host_rs(host_rs), .host_wdata(host_wdata),
        .host_safe(host_safe), .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
        .host_busy(host_busy), .cia_cs_n(cia_cs_n), .cia_rw(cia_rw), .cia_rs(cia_rs),
        .cia_db_in(cia_db_in), .cia_db_out(cia_db_out), .owner(owner)
    );

    initial forever #(CLK_P/2) clk = ~clk;

    int total = 0, bad = 0;
    logic [7:0] exp_mem [16] = '{default: 8'h00};

    // phi2 period of 8 clk: phi2_p at phase 0, phi2_n at phase 4
    int ph = 7, cpu_mode = 0, cpu_run = 0;
    logic once_pend = 1'b0, late_en = 1'b0;
    logic [3:0] once_rs = '0;
    logic [7:0] once_db = '0, once_late = '0, late_db = '0;
    initial forever begin
        @(negedge clk);
        ph = (ph + 1) % 8;
        phi2_p = (ph == 0);
        phi2_n = (ph == 4);
        if (ph == 0) begin
            cpu_cs_n = 1'b1;
            late_en  = 1'b0;
            case (cpu_mode)
                1: begin cpu_cs_n = 1'b0; cpu_rw = 1'b1; cpu_rs = 4'h4; end
                2: if (cpu_run < 2 && $urandom_range(0, 1) == 1) begin
                    cpu_cs_n = 1'b0;
                    cpu_rw   = 1'($urandom_range(0, 1));
                    cpu_rs   = 4'(4 + $urandom_range(0, 3));
                    cpu_db   = 8'($urandom);
                    late_en  = !cpu_rw && ($urandom_range(0, 1) == 1);
                    late_db  = 8'($urandom);
                end
                3: if (once_pend) begin
                    once_pend = 1'b0;
                    cpu_cs_n = 1'b0; cpu_rw = 1'b0; cpu_rs = once_rs; cpu_db = once_db;
                    late_en  = 1'b1; late_db = once_late;
                end
                default: ;
            endcase
            cpu_run = cpu_cs_n ? 0 : cpu_run + 1;
        end
        if (ph == 2 && late_en) cpu_db = late_db;
        if (ph == 4 && !cpu_cs_n && !cpu_rw) exp_mem[cpu_rs] = cpu_db;
        if (ph == 5) cpu_cs_n = 1'b1;
    end

    // CIA stand-in: plain registers, reading ICR (D) clears it, db_out registered on phi2_n
    logic [7:0] cia_mem [16] = '{default: 8'h00};
    int host_acc = 0, cpu_acc = 0, win_cnt = 0, p_cnt = 0, owner_cnt = 0, h_pc = 0, c_pc = 0;
    logic cs_prev = 1'b1, lh_rw = 1'b1;
    logic [3:0] lh_rs = '0;
    logic [7:0] lh_db = '0, lc_db = '0;
    longint pn_host_t = 0;
    always @(posedge clk) begin
        cs_prev <= cia_cs_n;
        if (cs_prev && !cia_cs_n) win_cnt <= win_cnt + 1;
        if (phi2_p && !phi2_n) p_cnt <= p_cnt + 1;
        if (owner) owner_cnt <= owner_cnt + 1;
        if (phi2_n && !cia_cs_n) begin
            if (cia_rw) begin
                cia_db_out <= cia_mem[cia_rs];
                if (cia_rs == 4'hD) cia_mem[4'hD] <= 8'h00;
            end else begin
                cia_mem[cia_rs] <= cia_db_in;
            end
            if (owner) begin
                host_acc <= host_acc + 1;
                lh_rw <= cia_rw; lh_rs <= cia_rs; lh_db <= cia_db_in;
                h_pc <= p_cnt; pn_host_t <= $time;
            end else begin
                cpu_acc <= cpu_acc + 1;
                lc_db <= cia_db_in; c_pc <= p_cnt;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ph(input int p);
        int n = 0;
        while (ph != p && n < 20) begin tick(); n++; end
    endtask

    logic a_seen, a_err;
    logic [7:0] a_rd;
    int a_ticks;
    longint t_ack;
    task automatic host_op(input logic rw, input logic [3:0] rs, input logic [7:0] wd, input logic safe);
        host_req = 1'b1; host_rw = rw; host_rs = rs; host_wdata = wd; host_safe = safe;
        a_seen = 1'b0; a_err = 1'b0; a_rd = '0; a_ticks = 0;
        while (!a_seen && a_ticks < 300) begin
            tick();
            a_ticks++;
            if (host_ack) begin
                a_seen = 1'b1; a_err = host_err; a_rd = host_rdata; host_req = 1'b0;
            end
        end
        host_req = 1'b0;
        t_ack = $time;
    endtask

    int ha0, wc0, pc0, oc0;
    logic r_rw, r_safe, refused;
    logic [3:0] r_rs;
    logic [7:0] r_wd;

    initial begin
        repeat (3) tick();
        check("rst_cs_n", 32'(cia_cs_n), 1);
        check("rst_rw", 32'(cia_rw), 1);
        check("rst_rs", 32'(cia_rs), 0);
        check("rst_db", 32'(cia_db_in), 0);
        check("rst_ack_err", {host_ack, host_err}, 0);
        check("rst_rdata", 32'(host_rdata), 0);
        check("rst_busy_owner", {host_busy, owner}, 0);
        res_n = 1'b1;
        repeat (10) tick();
        check("idle_cs_n", 32'(cia_cs_n), 1);

        // host write on an idle bus
        wc0 = win_cnt; ha0 = host_acc;
        host_op(1'b0, 4'h2, 8'hFF, 1'b0);
        exp_mem[2] = 8'hFF;
        check("wr_ack", 32'(a_seen), 1);
        check("wr_err", 32'(a_err), 0);
        check("wr_windows", 32'(win_cnt - wc0), 1);
        check("wr_host_acc", 32'(host_acc - ha0), 1);
        check("wr_bus", {lh_rw, lh_rs, lh_db}, {1'b0, 4'h2, 8'hFF});
        check("wr_ddra", 32'(cia_mem[2]), 32'hFF);
        tick();

        // host read back with latency check
        host_op(1'b1, 4'h2, 8'h00, 1'b0);
        check("rd_ack", 32'(a_seen), 1);
        check("rd_err", 32'(a_err), 0);
        check("rd_data", 32'(a_rd), 32'hFF);
        check("rd_latency", 32'(t_ack - 6 - pn_host_t), CLK_P);
        check("rd_busy_clr", 32'(host_busy), 0);
        tick();

        // safe refusal of an ICR read, then a real read
        host_op(1'b0, 4'hD, 8'h5A, 1'b0);
        exp_mem[13] = 8'h5A;
        tick();
        wc0 = win_cnt; ha0 = host_acc;
        host_op(1'b1, 4'hD, 8'h00, 1'b1);
        check("safe_ack", 32'(a_seen), 1);
        check("safe_err", 32'(a_err), 1);
        check("safe_latency", 32'(a_ticks), 2);
        check("safe_no_bus", 32'(win_cnt - wc0), 0);
        check("safe_icr_kept", 32'(cia_mem[13]), 32'h5A);
        tick();
        host_op(1'b1, 4'hD, 8'h00, 1'b0);
        exp_mem[13] = 8'h00;
        check("unsafe_err", 32'(a_err), 0);
        check("unsafe_data", 32'(a_rd), 32'h5A);
        check("unsafe_icr_clr", 32'(cia_mem[13]), 0);
        tick();

        // CPU owns every cycle: host read times out after TO phi2_p edges
        cpu_mode = 1;
        wait_ph(6);
        pc0 = p_cnt; oc0 = owner_cnt; ha0 = host_acc;
        host_op(1'b1, 4'h0, 8'h00, 1'b0);
        check("to_ack", 32'(a_seen), 1);
        check("to_err", 32'(a_err), 1);
        check("to_phi2_p", 32'(p_cnt - pc0), TO);
        check("to_owner", 32'(owner_cnt - oc0), 0);
        check("to_no_host", 32'(host_acc - ha0), 0);
        cpu_mode = 0;
        repeat (8) tick();

        // CPU write with late data in cycle N, host takes cycle N+1
        cpu_mode = 3;
        wait_ph(6);
        once_rs = 4'h6; once_db = 8'h11; once_late = 8'hC3; once_pend = 1'b1;
        host_op(1'b0, 4'h1, 8'h77, 1'b0);
        exp_mem[1] = 8'h77;
        check("il_err", 32'(a_err), 0);
        check("il_late_db", 32'(lc_db), 32'hC3);
        check("il_cpu_reg", 32'(cia_mem[6]), 32'hC3);
        check("il_next_cycle", 32'(h_pc - c_pc), 1);
        check("il_host_reg", 32'(cia_mem[1]), 32'h77);
        cpu_mode = 0;
        repeat (8) tick();

        // reset while the host owns the bus
        ha0 = host_acc;
        host_req = 1'b1; host_rw = 1'b0; host_rs = 4'h3; host_wdata = 8'hEE; host_safe = 1'b0;
        a_ticks = 0;
        while (!(owner && !cia_cs_n) && a_ticks < 40) begin tick(); a_ticks++; end
        check("rst_h_reached", 32'(owner && !cia_cs_n), 1);
        #1 res_n = 1'b0;
        host_req = 1'b0;
        #1;
        check("rst_h_cs_n", 32'(cia_cs_n), 1);
        check("rst_h_busy_owner", {host_busy, owner}, 0);
        a_seen = 1'b0;
        repeat (3) begin tick(); if (host_ack) a_seen = 1'b1; end
        res_n = 1'b1;
        repeat (12) begin tick(); if (host_ack) a_seen = 1'b1; end
        check("rst_h_no_ack", 32'(a_seen), 0);
        check("rst_h_no_write", 32'(host_acc - ha0), 0);
        host_op(1'b0, 4'h3, 8'h3C, 1'b0);
        exp_mem[3] = 8'h3C;
        tick();
        host_op(1'b1, 4'h3, 8'h00, 1'b0);
        check("rst_h_after", {a_seen, a_err, a_rd}, {1'b1, 1'b0, 8'h3C});

        // random host traffic against random CPU traffic (never 3 CPU cycles in a row)
        cpu_mode = 2;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 9)) tick();
            r_rw = 1'($urandom_range(0, 1));
            r_rs = 4'($urandom_range(0, 15));
            r_wd = 8'($urandom);
            r_safe = 1'($urandom_range(0, 1));
            refused = r_rw && r_safe && (r_rs == 4'h8 || r_rs == 4'hB || r_rs == 4'hD);
            ha0 = host_acc;
            host_op(r_rw, r_rs, r_wd, r_safe);
            check("rnd_ack", 32'(a_seen), 1);
            check("rnd_err", 32'(a_err), 32'(refused));
            check("rnd_host_acc", 32'(host_acc - ha0), refused ? 0 : 1);
            if (!refused) begin
                if (r_rw) begin
                    check("rnd_rdata", 32'(a_rd), 32'(exp_mem[r_rs]));
                    if (r_rs == 4'hD) exp_mem[13] = 8'h00;
                end else begin
                    exp_mem[r_rs] = r_wd;
                end
            end
        end
        cpu_mode = 0;
        repeat (10) tick();
        for (int r = 0; r < 16; r++) check("final_mem", 32'(cia_mem[r]), 32'(exp_mem[r]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
